// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller:
// FSM state codes, the default HALT encoding and byte-per-word geometry.
package imem_load_ctrl_pkg;

   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

   localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_READY = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_STEP  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // A reload may only begin while the CPU is not executing and no load is in flight.
   function automatic logic load_allowed(input logic [2:0] st);
      return (st == ST_IDLE) || (st == ST_READY) || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/imem_load_ctrl_byte_word_packer.sv
// Assembles a word from a byte stream, most significant byte first.
// word_done/word_next are combinational so the owner can register the
// memory write on the same edge that accepts the final byte.
module imem_load_ctrl_byte_word_packer
   import imem_load_ctrl_pkg::*;
#(
   parameter int PACK_W = WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              word_done,
   output logic [PACK_W-1:0] word_next
);

   localparam int BYTES = PACK_W / BYTE_W;
   localparam int CNT_W = $clog2(BYTES);

   logic [PACK_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;

   assign accept    = enable && rx_valid;
   assign word_next = {shift_q[PACK_W-BYTE_W-1:0], rx_data};
   assign word_done = accept && (cnt_q == CNT_W'(BYTES - 1));

   // Shift each accepted byte in from the right and count bytes within the word.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (accept) begin
         shift_d = word_next;
         cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Assembly registers; reset drops any partially built word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: loads a program from the debug byte stream,
// then releases the CPU in continuous-run or single-step mode and freezes it
// again when the HALT word is fetched.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                MEM_DEPTH = 128,
   parameter logic [ADDR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic              run_req,
   input  logic              step_req,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic [ADDR_W-1:0] cpu_fetch_addr,
   input  logic [ADDR_W-1:0] instr_in,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [ADDR_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              cpu_stall,
   output logic [ADDR_W-1:0] prog_len,
   output logic              loaded,
   output logic              load_err,
   output logic [2:0]        state_o
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
   logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_stall_q, cpu_stall_d;
   logic [ADDR_W-1:0] prog_len_q, prog_len_d;
   logic              loaded_q, loaded_d;
   logic              load_err_q, load_err_d;

   logic              start_load;
   logic              word_done;
   logic [ADDR_W-1:0] word_next;
   logic              halt_fetched;

   imem_load_ctrl_byte_word_packer #(
      .PACK_W (ADDR_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_load),
      .enable    (state_q == ST_LOAD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .word_done (word_done),
      .word_next (word_next)
   );

   assign halt_fetched = !cpu_stall_q && (instr_in == HALT_WORD);

   // Next-state logic: load sequencing, run/step release and HALT detection.
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      mem_we_d    = 1'b0;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_stall_d = cpu_stall_q;
      prog_len_d  = prog_len_q;
      loaded_d    = loaded_q;
      load_err_d  = load_err_q;

      case (state_q)
         ST_IDLE: begin
            cpu_stall_d = 1'b1;
         end
         ST_LOAD: begin
            if (word_done && (word_idx_q < ADDR_W'(MEM_DEPTH))) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = word_idx_q;
               mem_wdata_d = word_next;
               word_idx_d  = word_idx_q + ADDR_W'(1);
               if (word_next == HALT_WORD) begin
                  prog_len_d = word_idx_q + ADDR_W'(1);
                  loaded_d   = 1'b1;
                  state_d    = ST_READY;
               end else if (word_idx_q == ADDR_W'(MEM_DEPTH - 1)) begin
                  load_err_d = 1'b1;
                  prog_len_d = ADDR_W'(MEM_DEPTH);
                  loaded_d   = 1'b1;
                  state_d    = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (run_req) begin
               state_d     = ST_RUN;
               cpu_stall_d = 1'b0;
            end else if (step_req) begin
               state_d     = ST_STEP;
               cpu_stall_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (halt_fetched) begin
               state_d     = ST_DONE;
               cpu_stall_d = 1'b1;
            end
         end
         ST_STEP: begin
            cpu_stall_d = 1'b1;
            state_d     = halt_fetched ? ST_DONE : ST_READY;
         end
         ST_DONE: begin
            cpu_stall_d = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            cpu_stall_d = 1'b1;
         end
      endcase

      // run/step in READY take precedence, so a load only starts if nothing else moved the FSM.
      start_load = load_req && load_allowed(state_q) && (state_d == state_q);
      if (start_load) begin
         state_d     = ST_LOAD;
         word_idx_d  = '0;
         load_err_d  = 1'b0;
         cpu_stall_d = 1'b1;
      end
   end

   // Controller state registers; memory contents outside this block are untouched by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         word_idx_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
         cpu_stall_q <= 1'b1;
         prog_len_q  <= '0;
         loaded_q    <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         mem_we_q    <= mem_we_d;
         mem_waddr_q <= mem_waddr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_stall_q <= cpu_stall_d;
         prog_len_q  <= prog_len_d;
         loaded_q    <= loaded_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_raddr = (state_q == ST_LOAD) ? word_idx_q : cpu_fetch_addr;
   assign mem_we    = mem_we_q;
   assign mem_waddr = mem_waddr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_stall = cpu_stall_q;
   assign prog_len  = prog_len_q;
   assign loaded    = loaded_q;
   assign load_err  = load_err_q;
   assign state_o   = state_q;

endmodule
